// File: rtl/rv32i_types.sv
// Shared RV32I datapath types: LSQ dispatch entries, CDB broadcasts and the
// funct3 encodings of the load instructions.
package rv32i_types;

    localparam int RV_XLEN  = 32;
    localparam int PREG_W   = 6;
    localparam int ROB_W    = 4;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [RV_XLEN-1:0] imm;
        logic [2:0]         funct3;
        logic [PREG_W-1:0]  pd;
        logic [ROB_W-1:0]   rob_idx;
    } dispatch_to_lsq_t;

    typedef struct packed {
        logic             valid;
        dispatch_to_lsq_t data;
    } lsq_entry_t;

    typedef struct packed {
        logic               valid;
        logic [PREG_W-1:0]  pd;
        logic [ROB_W-1:0]   rob_idx;
        logic [RV_XLEN-1:0] value;
    } cdb_entry_t;

endpackage

// File: rtl/load_align.sv
// Byte-lane mask generation and sign/zero extension of load data for a
// word-wide memory port.
module load_align
    import rv32i_types::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      rmask,
    output logic [XLEN-1:0] value
);

    logic signed [7:0]  byte_sel;
    logic signed [15:0] half_sel;

    function automatic logic [XLEN-1:0] sext_byte(input logic signed [7:0] b);
        return {{(XLEN-8){b[7]}}, b};
    endfunction

    function automatic logic [XLEN-1:0] sext_half(input logic signed [15:0] h);
        return {{(XLEN-16){h[15]}}, h};
    endfunction

    assign byte_sel = rdata[8*addr_lo +: 8];
    assign half_sel = rdata[16*addr_lo[1] +: 16];

    // Unknown funct3 falls back to a full-word read
    always_comb begin
        rmask = 4'b1111;
        value = rdata;
        case (funct3)
            F3_LB: begin
                rmask = 4'b0001 << addr_lo;
                value = sext_byte(byte_sel);
            end
            F3_LBU: begin
                rmask = 4'b0001 << addr_lo;
                value = {{(XLEN-8){1'b0}}, byte_sel};
            end
            F3_LH: begin
                rmask = 4'b0011 << {addr_lo[1], 1'b0};
                value = sext_half(half_sel);
            end
            F3_LHU: begin
                rmask = 4'b0011 << {addr_lo[1], 1'b0};
                value = {{(XLEN-16){1'b0}}, half_sel};
            end
            default: begin
                rmask = 4'b1111;
                value = rdata;
            end
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Single-outstanding load unit: takes a ready load from the RS, issues one
// data-memory read, aligns the result and holds it on the CDB until granted.
module load_unit
    import rv32i_types::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  lsq_entry_t      lsq_to_adder,
    output logic            lsq_dequeue,
    input  logic            flush,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_rmask,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_resp,
    output cdb_entry_t      cdb_out,
    input  logic            cdb_grant,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, MEM_WAIT, CDB_WAIT, DRAIN} state_t;

    state_t            state;
    dispatch_to_lsq_t  ld_p1;
    logic [3:0]        rmask_p1;
    logic [XLEN-1:0]   value_p1;
    logic              req_active;
    logic              cdb_vld_p2;
    logic [PREG_W-1:0] pd_p2;
    logic [ROB_W-1:0]  rob_p2;
    logic [XLEN-1:0]   value_p2;

    load_align #(.XLEN(XLEN)) u_align (
        .funct3  (ld_p1.funct3),
        .addr_lo (ld_p1.imm[1:0]),
        .rdata   (dmem_rdata),
        .rmask   (rmask_p1),
        .value   (value_p1)
    );

    // Reset gates acceptance directly since state alone reads IDLE during reset
    assign lsq_dequeue = rst && (state == IDLE) && lsq_to_adder.valid && !flush;
    assign busy        = (state != IDLE);

    // A squashed request stays on the port in DRAIN until memory answers
    assign req_active = (state == MEM_WAIT) || (state == DRAIN);
    assign dmem_addr  = req_active ? {ld_p1.imm[XLEN-1:2], 2'b00} : '0;
    assign dmem_rmask = req_active ? rmask_p1 : 4'b0000;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cdb_vld_p2 <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cdb_vld_p2 <= 1'b0;
                    if (lsq_dequeue) state <= MEM_WAIT;
                end
                MEM_WAIT: begin
                    if (dmem_resp) begin
                        if (flush) begin
                            state <= IDLE;
                        end else begin
                            state      <= CDB_WAIT;
                            cdb_vld_p2 <= 1'b1;
                        end
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end
                CDB_WAIT: begin
                    if (flush || cdb_grant) begin
                        state      <= IDLE;
                        cdb_vld_p2 <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (dmem_resp) state <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    cdb_vld_p2 <= 1'b0;
                end
            endcase
        end
    end

    // ---- p1: accepted load entry ----
    always_ff @(posedge clk) begin
        if (lsq_dequeue) ld_p1 <= lsq_to_adder.data;
    end

    // ---- p2: aligned result awaiting CDB grant ----
    always_ff @(posedge clk) begin
        if ((state == MEM_WAIT) && dmem_resp && !flush) begin
            pd_p2    <= ld_p1.pd;
            rob_p2   <= ld_p1.rob_idx;
            value_p2 <= (ld_p1.pd == '0) ? '0 : value_p1;
        end
    end

    assign cdb_out.valid   = cdb_vld_p2;
    assign cdb_out.pd      = pd_p2;
    assign cdb_out.rob_idx = rob_p2;
    assign cdb_out.value   = value_p2;

endmodule
